display_scan: RTL and testbench

Time-multiplexed scan controller for a common-anode bank of hex seven-segment digits. It sits directly upstream of the per-digit hex-to-segment decoder. It holds a multi-digit value, cycles through the digits at a prescaled rate, and presents one 4-bit nibble at a time to the decoder as {A3,A2,A1,A0}, together with an active-low anode select. New values are double-buffered so a digit never shows a mix of old and new data within one frame.

---
 rtl/display_scan.sv | 141 ++++++++++++++
 tb/tb_display_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan
//
// Time-multiplexed scan controller for a common-anode bank of hex
// seven-segment digits. A prescaler divides the clock into digit slots.
// The digit index walks through the digits, one slot each. The nibble for
// the current digit goes to a downstream hex-to-segment decoder together
// with an active-low one-hot anode select.
//
// New values are double-buffered. A load only writes the shadow register.
// The shadow moves into the active register at a frame boundary, so one
// frame never mixes old and new data.
//
// Optional feature: define DISPLAY_SCAN_LZB_EN to enable leading-zero
// blanking. When it is undefined, blank is tied low. The port list is the
// same in both builds.
//
// Parameters:
//   DIGITS     number of digits scanned (1..8)
//   PRESCALE   clock cycles per digit slot (>= 1)
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   load        one-cycle strobe that captures value into the shadow register
//   value       4*DIGITS bits; digit i is value[4i+3:4i]
//   nibble      current digit code; bit 3 = A3 ... bit 0 = A0
//   digit_an    active-low one-hot anode select; all ones when blanked
//   blank       current digit must be dark
//   pending     shadow holds a value not yet displayed
//   frame_done  one-cycle pulse in the first cycle of each frame
module display_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_an,
  output logic                  blank,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int PC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PC_W-1:0]     pc_q, pc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;

  logic tc;
  logic fb;

  // Slot and frame sequencing. A load in the boundary cycle wins over the
  // pending clear: active takes the old shadow, and the new value waits in
  // the shadow for the next boundary.
  always_comb begin
    tc = (pc_q == PC_W'(PRESCALE - 1));
    fb = tc && (idx_q == IDX_W'(DIGITS - 1));

    pc_d         = tc ? '0 : pc_q + 1'b1;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = fb;

    if (tc) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    if (fb) begin
      if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end

    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Output decode. It uses only registered state, so no input can reach an
  // output combinationally.
  always_comb begin
    logic [DIGITS-1:0] zero_from;
    logic              all_zero;

    nibble    = 4'h0;
    zero_from = '0;
    all_zero  = 1'b1;

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble = active_q[4*i +: 4];
      end
    end

    // zero_from[i] is set when digit i and every higher digit are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (active_q[4*i +: 4] == 4'h0);
      zero_from[i] = all_zero;
    end

`ifdef DISPLAY_SCAN_LZB_EN
    blank = (idx_q != '0) && zero_from[idx_q];
`else
    blank = 1'b0 & zero_from[0];
`endif

    digit_an = blank ? '1 : ~(DIGITS'(1) << idx_q);
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
//
// Self-checking bench for display_scan with DIGITS=4 and PRESCALE=4.
// A table of per-segment records gives the input drive, the repeat count
// and the expected outputs after each clock edge. Each record also carries
// an "lzb" flag. The flag marks slots that are dark when leading-zero
// blanking is compiled in. After the table, a hand-written sequence
// measures the frame_done spacing.
module tb_display_scan;

`ifdef DISPLAY_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  nibble;
  logic [3:0]  digit_an;
  logic        blank;
  logic        pending;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  display_scan #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .nibble     (nibble),
    .digit_an   (digit_an),
    .blank      (blank),
    .pending    (pending),
    .frame_done (frame_done)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    int          count;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        pend;
    logic        fd;
    logic        lzb;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic l, input logic [15:0] v,
                        input int n, input logic [3:0] nib, input logic [3:0] an,
                        input logic p, input logic fd, input logic z);
    vec_t e;
    e.rst_n = r; e.load = l; e.value = v; e.count = n;
    e.nib = nib; e.an = an; e.pend = p; e.fd = fd; e.lzb = z;
    vecs.push_back(e);
  endtask

  // Drive inputs away from the rising edge, then sample 1 unit after it.
  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v);
    @(negedge clk);
    rst_n = r;
    load  = l;
    value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int row, input logic [3:0] nib,
                             input logic [3:0] an, input logic p, input logic fd,
                             input logic z);
    logic       exp_blank;
    logic [3:0] exp_an;
    exp_blank = LZB & z;
    exp_an    = exp_blank ? 4'b1111 : an;
    checks++;
    if (nibble !== nib || digit_an !== exp_an || blank !== exp_blank ||
        pending !== p || frame_done !== fd) begin
      failures++;
      $display("[TB] FAIL %s row %0d: got nib=%h an=%b blank=%b pend=%b fd=%b, want nib=%h an=%b blank=%b pend=%b fd=%b",
               name, row, nibble, digit_an, blank, pending, frame_done,
               nib, exp_an, exp_blank, p, fd);
    end
  endtask

  initial begin
    int gap;
    bit seen;

    // reset
    addVec(0, 0, 16'h0000, 2, 4'h0, 4'b1110, 0, 0, 0);
    // scan 1A3F: load in the first cycle after release, shown from cycle 16
    addVec(1, 1, 16'h1A3F, 1, 4'h0, 4'b1110, 1, 0, 0);
    addVec(1, 0, 16'h0000, 2, 4'h0, 4'b1110, 1, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b1101, 1, 0, 1);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b1011, 1, 0, 1);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b0111, 1, 0, 1);
    addVec(1, 0, 16'h0000, 1, 4'hF, 4'b1110, 0, 1, 0);
    addVec(1, 0, 16'h0000, 3, 4'hF, 4'b1110, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h3, 4'b1101, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'hA, 4'b1011, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h1, 4'b0111, 0, 0, 0);
    addVec(1, 0, 16'h0000, 1, 4'hF, 4'b1110, 0, 1, 0);
    // double load within one frame: 1111 then 2222, only 2222 is shown
    addVec(1, 1, 16'h1111, 1, 4'hF, 4'b1110, 1, 0, 0);
    addVec(1, 0, 16'h0000, 2, 4'hF, 4'b1110, 1, 0, 0);
    addVec(1, 1, 16'h2222, 1, 4'h3, 4'b1101, 1, 0, 0);
    addVec(1, 0, 16'h0000, 3, 4'h3, 4'b1101, 1, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'hA, 4'b1011, 1, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h1, 4'b0111, 1, 0, 0);
    addVec(1, 0, 16'h0000, 1, 4'h2, 4'b1110, 0, 1, 0);
    addVec(1, 0, 16'h0000, 3, 4'h2, 4'b1110, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h2, 4'b1101, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h2, 4'b1011, 0, 0, 0);
    // load 4567 late in the frame, then ABCD exactly on the fb cycle (63)
    addVec(1, 1, 16'h4567, 1, 4'h2, 4'b0111, 1, 0, 0);
    addVec(1, 0, 16'h0000, 3, 4'h2, 4'b0111, 1, 0, 0);
    addVec(1, 1, 16'hABCD, 1, 4'h7, 4'b1110, 1, 1, 0);
    addVec(1, 0, 16'h0000, 3, 4'h7, 4'b1110, 1, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h6, 4'b1101, 1, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h5, 4'b1011, 1, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h4, 4'b0111, 1, 0, 0);
    addVec(1, 0, 16'h0000, 1, 4'hD, 4'b1110, 0, 1, 0);
    addVec(1, 0, 16'h0000, 3, 4'hD, 4'b1110, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'hC, 4'b1101, 0, 0, 0);
    addVec(1, 0, 16'h0000, 2, 4'hB, 4'b1011, 0, 0, 0);
    // mid-frame reset at idx=2, with a pending load and a simultaneous load
    addVec(1, 1, 16'h9999, 1, 4'hB, 4'b1011, 1, 0, 0);
    addVec(0, 1, 16'h7777, 1, 4'h0, 4'b1110, 0, 0, 0);
    addVec(1, 0, 16'h0000, 3, 4'h0, 4'b1110, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b1101, 0, 0, 1);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b1011, 0, 0, 1);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b0111, 0, 0, 1);
    addVec(1, 0, 16'h0000, 1, 4'h0, 4'b1110, 0, 1, 0);
    // value 0050: digits 3 and 2 are leading zeros, digit 0 stays lit
    addVec(1, 1, 16'h0050, 1, 4'h0, 4'b1110, 1, 0, 0);
    addVec(1, 0, 16'h0000, 2, 4'h0, 4'b1110, 1, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b1101, 1, 0, 1);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b1011, 1, 0, 1);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b0111, 1, 0, 1);
    addVec(1, 0, 16'h0000, 1, 4'h0, 4'b1110, 0, 1, 0);
    addVec(1, 0, 16'h0000, 3, 4'h0, 4'b1110, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h5, 4'b1101, 0, 0, 0);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b1011, 0, 0, 1);
    addVec(1, 0, 16'h0000, 4, 4'h0, 4'b0111, 0, 0, 1);

    for (int r = 0; r < vecs.size(); r++) begin
      for (int k = 0; k < vecs[r].count; k++) begin
        applyStimulus(vecs[r].rst_n, vecs[r].load, vecs[r].value);
        checkOutput("vector", r, vecs[r].nib, vecs[r].an, vecs[r].pend,
                    vecs[r].fd, vecs[r].lzb);
      end
    end

    // The last row leaves the scan at cycle 47, so frame_done is due on the
    // next edge and again exactly 16 cycles after that.
    gap = 0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      applyStimulus(1, 0, 16'h0000);
      if (frame_done === 1'b1) begin
        seen = 1;
        gap = i;
      end
    end
    checks++;
    if (!seen || gap != 1) begin
      failures++;
      $display("[TB] FAIL fd_first: got seen=%0d after %0d cycles, want seen=1 after 1", seen, gap);
    end

    gap = 0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      applyStimulus(1, 0, 16'h0000);
      if (frame_done === 1'b1) begin
        seen = 1;
        gap = i;
      end
    end
    checks++;
    if (!seen || gap != 16) begin
      failures++;
      $display("[TB] FAIL fd_period: got seen=%0d gap=%0d, want seen=1 gap=16", seen, gap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
